// File: rtl/semaforo_agendador.sv
// Demand-actuated two-street traffic sequencer with a pedestrian phase.
// Define SEMAFORO_PISCA_EN to enable the night-mode yellow blink state.
module semaforo_agendador #(
  parameter int T_VERDE_MIN = 4,
  parameter int T_VERDE_MAX = 10,
  parameter int T_AMARELO   = 2,
  parameter int T_VERMELHO  = 1,
  parameter int T_PEDESTRE  = 3,
  parameter int T_PISCA     = 2,
  parameter int LARGURA     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_rua_1,
  input  logic       sensor_rua_2,
  input  logic       pedestre,
  input  logic       modo_noturno,
  output logic       rua_1_verde,
  output logic       rua_1_amarelo,
  output logic       rua_1_vermelho,
  output logic       rua_2_verde,
  output logic       rua_2_amarelo,
  output logic       rua_2_vermelho,
  output logic       pedestre_verde,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    R1_VERDE   = 3'd0,
    R1_AMARELO = 3'd1,
    VERM_A     = 3'd2,
    R2_VERDE   = 3'd3,
    R2_AMARELO = 3'd4,
    VERM_B     = 3'd5,
    PED        = 3'd6,
    PISCA      = 3'd7
  } estado_t;

  localparam logic [LARGURA-1:0] VMIN_FIM = LARGURA'(T_VERDE_MIN - 1);
  localparam logic [LARGURA-1:0] VMAX_FIM = LARGURA'(T_VERDE_MAX - 1);
  localparam logic [LARGURA-1:0] AMA_FIM  = LARGURA'(T_AMARELO - 1);
  localparam logic [LARGURA-1:0] VERM_FIM = LARGURA'(T_VERMELHO - 1);
  localparam logic [LARGURA-1:0] PED_FIM  = LARGURA'(T_PEDESTRE - 1);

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] cnt_q, cnt_d;
  logic               pedido_q, pedido_d;
  logic               proxima_q, proxima_d;
  logic               entra;
  logic               sai_r1, sai_r2;

`ifdef SEMAFORO_PISCA_EN
  localparam logic [LARGURA-1:0] PISCA_FIM = LARGURA'(T_PISCA - 1);
  logic pisca_q, pisca_d;
`else
  logic unused_modo;
  assign unused_modo = modo_noturno;
`endif

  // Green ends on gap-out (own street empty after minimum) or max-out, but only with waiting demand.
  assign sai_r1 = ((cnt_q >= VMAX_FIM) || ((cnt_q >= VMIN_FIM) && !sensor_rua_1))
                  && (sensor_rua_2 || pedido_q);
  assign sai_r2 = ((cnt_q >= VMAX_FIM) || ((cnt_q >= VMIN_FIM) && !sensor_rua_2))
                  && (sensor_rua_1 || pedido_q);
  assign entra  = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= R1_VERDE;
      cnt_q     <= '0;
      pedido_q  <= 1'b0;
      proxima_q <= 1'b0;
`ifdef SEMAFORO_PISCA_EN
      pisca_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pedido_q  <= pedido_d;
      proxima_q <= proxima_d;
`ifdef SEMAFORO_PISCA_EN
      pisca_q   <= pisca_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R1_VERDE:   if (sai_r1) state_d = R1_AMARELO;
      R1_AMARELO: if (cnt_q == AMA_FIM) state_d = VERM_A;
      VERM_A:     if (cnt_q == VERM_FIM) state_d = pedido_q ? PED : R2_VERDE;
      R2_VERDE:   if (sai_r2) state_d = R2_AMARELO;
      R2_AMARELO: if (cnt_q == AMA_FIM) state_d = VERM_B;
      VERM_B:     if (cnt_q == VERM_FIM) state_d = pedido_q ? PED : R1_VERDE;
      PED:        if (cnt_q == PED_FIM) state_d = proxima_q ? R2_VERDE : R1_VERDE;
`ifdef SEMAFORO_PISCA_EN
      PISCA:      if (!modo_noturno) state_d = VERM_B;
`endif
      default:    state_d = R1_VERDE;
    endcase
`ifdef SEMAFORO_PISCA_EN
    if (modo_noturno) state_d = PISCA;
`endif
  end

  // Phase counter, pedestrian latch and the street to serve after the walk phase.
  always_comb begin
    cnt_d     = cnt_q;
    pedido_d  = pedido_q;
    proxima_d = proxima_q;
    if (entra) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        R1_VERDE, R2_VERDE: if (cnt_q < VMAX_FIM) cnt_d = cnt_q + LARGURA'(1);
`ifdef SEMAFORO_PISCA_EN
        PISCA:   cnt_d = (cnt_q == PISCA_FIM) ? '0 : cnt_q + LARGURA'(1);
`endif
        default: cnt_d = cnt_q + LARGURA'(1);
      endcase
    end
`ifdef SEMAFORO_PISCA_EN
    if (pedestre && (state_q != PED) && (state_q != PISCA)) pedido_d = 1'b1;
    if (state_d == PISCA) pedido_d = 1'b0;
`else
    if (pedestre && (state_q != PED)) pedido_d = 1'b1;
`endif
    if (entra && (state_d == PED)) begin
      pedido_d  = 1'b0;
      proxima_d = (state_q == VERM_A);
    end
  end

`ifdef SEMAFORO_PISCA_EN
  always_comb begin
    pisca_d = pisca_q;
    if (entra) pisca_d = 1'b1;
    else if ((state_q == PISCA) && (cnt_q == PISCA_FIM)) pisca_d = ~pisca_q;
  end
`endif

  always_comb begin
    rua_1_verde    = 1'b0;
    rua_1_amarelo  = 1'b0;
    rua_1_vermelho = 1'b0;
    rua_2_verde    = 1'b0;
    rua_2_amarelo  = 1'b0;
    rua_2_vermelho = 1'b0;
    pedestre_verde = 1'b0;
    case (state_q)
      R1_VERDE:   begin rua_1_verde   = 1'b1; rua_2_vermelho = 1'b1; end
      R1_AMARELO: begin rua_1_amarelo = 1'b1; rua_2_vermelho = 1'b1; end
      R2_VERDE:   begin rua_2_verde   = 1'b1; rua_1_vermelho = 1'b1; end
      R2_AMARELO: begin rua_2_amarelo = 1'b1; rua_1_vermelho = 1'b1; end
      PED: begin
        rua_1_vermelho = 1'b1;
        rua_2_vermelho = 1'b1;
        pedestre_verde = 1'b1;
      end
`ifdef SEMAFORO_PISCA_EN
      PISCA: begin
        rua_1_amarelo = pisca_q;
        rua_2_amarelo = pisca_q;
      end
`endif
      default: begin rua_1_vermelho = 1'b1; rua_2_vermelho = 1'b1; end
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_semaforo_agendador.sv
// Scoreboard bench for semaforo_agendador: stimulus queues per-cycle expected
// state and lamps, a negedge monitor pops and compares them.
module tb_semaforo_agendador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_rua_1 = 1'b0;
  logic       sensor_rua_2 = 1'b0;
  logic       pedestre = 1'b0;
  logic       modo_noturno = 1'b0;
  logic       rua_1_verde, rua_1_amarelo, rua_1_vermelho;
  logic       rua_2_verde, rua_2_amarelo, rua_2_vermelho;
  logic       pedestre_verde;
  logic [2:0] estado;

  typedef struct packed {
    logic [2:0] estado;
    logic [6:0] lamps;
  } expect_t;

  expect_t expQ[$];
  int checks = 0;
  int errors = 0;

  semaforo_agendador dut (
    .clk(clk), .rst(rst),
    .sensor_rua_1(sensor_rua_1), .sensor_rua_2(sensor_rua_2),
    .pedestre(pedestre), .modo_noturno(modo_noturno),
    .rua_1_verde(rua_1_verde), .rua_1_amarelo(rua_1_amarelo), .rua_1_vermelho(rua_1_vermelho),
    .rua_2_verde(rua_2_verde), .rua_2_amarelo(rua_2_amarelo), .rua_2_vermelho(rua_2_vermelho),
    .pedestre_verde(pedestre_verde), .estado(estado)
  );

  always #5 clk = ~clk;

  // Lamp order: {r1 green, r1 yellow, r1 red, r2 green, r2 yellow, r2 red, walk}
  function automatic logic [6:0] lampsFor(input logic [2:0] e, input logic blink);
    case (e)
      3'd0:    return 7'b100_001_0;
      3'd1:    return 7'b010_001_0;
      3'd3:    return 7'b001_100_0;
      3'd4:    return 7'b001_010_0;
      3'd6:    return 7'b001_001_1;
      3'd7:    return {1'b0, blink, 1'b0, 1'b0, blink, 1'b0, 1'b0};
      default: return 7'b001_001_0;
    endcase
  endfunction

  // Drives one cycle of inputs and queues the state expected during that cycle.
  task automatic applyStimulus(input logic r, input logic s1, input logic s2,
                               input logic p, input logic m, input logic [2:0] e,
                               input logic b, input logic chk);
    expect_t x;
    @(posedge clk);
    #1;
    rst          = r;
    sensor_rua_1 = s1;
    sensor_rua_2 = s2;
    pedestre     = p;
    modo_noturno = m;
    if (chk) begin
      x.estado = e;
      x.lamps  = lampsFor(e, b);
      expQ.push_back(x);
    end
  endtask

  task automatic checkOutput(input expect_t x);
    logic [6:0] act;
    act = {rua_1_verde, rua_1_amarelo, rua_1_vermelho,
           rua_2_verde, rua_2_amarelo, rua_2_vermelho, pedestre_verde};
    checks++;
    if (estado !== x.estado) begin
      errors++;
      $display("[TB] FAIL estado at %0t: got %0d expected %0d", $time, estado, x.estado);
    end
    checks++;
    if (act !== x.lamps) begin
      errors++;
      $display("[TB] FAIL lamps at %0t: got %b expected %b", $time, act, x.lamps);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] e;
    logic       m;
    $display("[TB] start");

    // Idle intersection rests in street 1 green; without the night feature modo is ignored.
`ifdef SEMAFORO_PISCA_EN
    m = 1'b0;
`else
    m = 1'b1;
`endif
    doReset();
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, m, 3'd0, 1'b0, 1'b1);

    // Street 2 demand only: gap-out after minimum green, then rest in street 2 green.
    doReset();
    for (int i = 0; i < 15; i++) begin
      e = (i <= 3) ? 3'd0 : (i <= 5) ? 3'd1 : (i == 6) ? 3'd2 : 3'd3;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e, 1'b0, 1'b1);
    end

    // Both streets demanding: max-out alternation.
    doReset();
    for (int i = 0; i < 30; i++) begin
      e = (i <= 9) ? 3'd0 : (i <= 11) ? 3'd1 : (i == 12) ? 3'd2 :
          (i <= 22) ? 3'd3 : (i <= 24) ? 3'd4 : (i == 25) ? 3'd5 : 3'd0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e, 1'b0, 1'b1);
    end

    // Pedestrian press at cycle 1; press at cycle 8 falls inside the walk and is dropped.
    doReset();
    for (int i = 0; i < 20; i++) begin
      e = (i <= 3) ? 3'd0 : (i <= 5) ? 3'd1 : (i == 6) ? 3'd2 : (i <= 9) ? 3'd6 : 3'd3;
      applyStimulus(1'b0, 1'b0, 1'b0, (i == 1) || (i == 8), 1'b0, e, 1'b0, 1'b1);
    end

    // Reset during street 2 yellow with a pending press: request is lost.
    doReset();
    for (int i = 0; i < 26; i++) begin
      e = (i <= 3) ? 3'd0 : (i <= 5) ? 3'd1 : (i == 6) ? 3'd2 :
          (i <= 10) ? 3'd3 : (i == 11) ? 3'd4 : 3'd0;
      applyStimulus(i == 11, 1'b0, i <= 7, i == 8, 1'b0, e, 1'b0, 1'b1);
    end

`ifdef SEMAFORO_PISCA_EN
    // Night mode from cycle 5 to 13, press during blink ignored, then clearance back to street 1.
    doReset();
    for (int i = 0; i < 20; i++) begin
      e = (i <= 5) ? 3'd0 : (i <= 14) ? 3'd7 : (i == 15) ? 3'd5 : 3'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, i == 9, (i >= 5) && (i <= 13), e,
                    (i >= 6) ? (((i - 6) / 2) % 2 == 0) : 1'b0, 1'b1);
    end
`endif

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/semaforo_agendador.md
# semaforo_agendador

Demand-actuated sequencer for a two-street intersection with one pedestrian crossing. It lights the six lamps directly and owns all phase timing: minimum and maximum green, yellow, all-red clearance and a pedestrian walk phase. It arbitrates the shared right-of-way between street 1, street 2 and pedestrian requests. It sits above the basic two-street light and replaces its free-running pulse advance with sensor-driven scheduling.

## Interface
- T_VERDE_MIN, 4: minimum green length in cycles (≥1).
- T_VERDE_MAX, 10: maximum green length under opposing demand (≥ T_VERDE_MIN).
- T_AMARELO, 2: yellow length in cycles (≥1).
- T_VERMELHO, 1: all-red clearance length in cycles (≥1).
- T_PEDESTRE, 3: pedestrian walk length in cycles (≥1).
- T_PISCA, 2: half-period of the night-mode yellow blink in cycles (≥1).
- LARGURA, 8: phase counter width; every T_* must be ≤ 2^LARGURA.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sensor_rua_1, sensor_rua_2  in  1 each  vehicle-present level per street.
- pedestre  in  1  pedestrian button, any pulse width ≥1 cycle.
- modo_noturno  in  1  night-mode request; ignored unless SEMAFORO_PISCA_EN is defined.
- rua_1_verde, rua_1_amarelo, rua_1_vermelho  out  1 each  street 1 lamps.
- rua_2_verde, rua_2_amarelo, rua_2_vermelho  out  1 each  street 2 lamps.
- pedestre_verde  out  1  walk lamp.
- estado  out  3  current state code, for debug.

## Operation
- States and codes:
  - R1_VERDE=0, R1_AMARELO=1, VERM_A=2
  - R2_VERDE=3, R2_AMARELO=4, VERM_B=5
  - PED=6, PISCA=7
- Lamps are Moore-decoded from the state register. Exactly one lamp per street is on, except in PISCA.
  - R1_VERDE: r1 green, r2 red.
  - R1_AMARELO: r1 yellow, r2 red.
  - R2_VERDE: r2 green, r1 red.
  - R2_AMARELO: r2 yellow, r1 red.
  - VERM_A, VERM_B, PED: both red.
  - PED also drives pedestre_verde=1.
- Phase counter `cnt` clears to 0 on every state entry and increments each cycle in that state.
- Green exit for street X (own = sensor X, other = sensor of the other street, pedido = latched pedestrian request):
  - Gap-out: cnt ≥ T_VERDE_MIN-1, own=0, and (other or pedido).
  - Max-out: cnt ≥ T_VERDE_MAX-1 and (other or pedido).
  - Otherwise rest in green. `cnt` saturates at T_VERDE_MAX-1.
- Timed states end when cnt == T-1:
  - yellow → its all-red state;
  - VERM_A → PED if pedido, else R2_VERDE;
  - VERM_B → PED if pedido, else R1_VERDE;
  - PED → green of the street opposite the one served before PED. A 1-bit `proxima` register holds that choice.
- Pedestrian latch `pedido`:
  - Set when pedestre=1, except while in PED.
  - Cleared on the cycle PED is entered; clear wins over a simultaneous set.
  - Presses during PED are dropped.
- Reset values:
  - state R1_VERDE, cnt 0, pedido 0, proxima 0.
  - Outputs: rua_1_verde=1, rua_2_vermelho=1, every other lamp 0, estado=0.
- Reset mid-phase, any state: the next cycle shows the reset values and any pending pedido is lost.

## Timing
- Latency:
  - Sensor or pedido change to state change: 1 edge.
  - State change to lamps: same cycle, since lamps decode combinationally from the state register.
  - pedestre to pedido: 1 edge.
- Phase lengths: yellow, all-red and PED last exactly T_AMARELO, T_VERMELHO and T_PEDESTRE cycles.
- Green length:
  - Gap-out: exactly T_VERDE_MIN cycles when demand is already present.
  - Max-out: exactly T_VERDE_MAX cycles.
  - No demand: unbounded.
- Both sensors high: strict alternation at T_VERDE_MAX.

## Configuration
- SEMAFORO_PISCA_EN defined:
  - modo_noturno=1 in any state forces next state PISCA, with cnt=0 and pedido cleared.
  - In PISCA, both yellows equal a blink bit and all other lamps are 0.
  - The blink bit is 1 on entry and toggles when cnt == T_PISCA-1; cnt then restarts.
  - modo_noturno=0 in PISCA → VERM_B, so normal sequence resumes via clearance into R1_VERDE.
  - pedestre is ignored while in PISCA.
- SEMAFORO_PISCA_EN undefined: the modo_noturno port exists but is ignored, and state code 7 is unreachable.

## Test plan
Defaults apply; cycle 0 is the first edge after rst falls.
- No sensors, no button for 50 cycles → estado=0 throughout; rua_1_verde=1 and rua_2_vermelho=1 constant.
- sensor_rua_2=1 held, sensor_rua_1=0 → estado 0 on cycles 0–3, 1 on 4–5, 2 on 6, 3 from 7 onward (rests there).
- Both sensors held → R1 green 0–9, yellow 10–11, red 12, R2 green 13–22, yellow 23–24, red 25, R1 green 26.
- pedestre pulsed 1 cycle at cycle 1, no sensors → yellow 4–5, red 6, estado 6 with pedestre_verde=1 on cycles 7–9, R2_VERDE from 10; a second press on cycle 8 is dropped.
- rst=1 for 1 cycle during R2_AMARELO with pedido pending → next cycle estado=0, reset lamp values, pedido=0; with no sensors, rests in R1 green.
- Macro defined, modo_noturno=1 at cycle 5:
  - estado=7 from cycle 6; both yellows 1,1,0,0,1… in 2-cycle halves.
  - Drop modo_noturno → estado 5 for 1 cycle, then 0.
